// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundles the time word, AM flag and display outputs of the six-digit
// seven-segment scan driver.
//   digi_clock [23:0] packed BCD time hh:mm:ss (hour tens in [23:20])
//   AM                1 = AM
//   blank_lz          1 = hide a leading zero in the hour-tens digit
//   seg        [6:0]  segments {g,f,e,d,c,b,a}, active-low
//   dig_en     [5:0]  digit enables, active-low, bit 5 = hour tens
//   colon             colon LED, active-high
//   am_led            AM LED, active-high
// master: the source of the time word (clock top level / bench).
// slave : the scan driver.
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if;
    logic [23:0] digi_clock;
    logic        AM;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [5:0]  dig_en;
    logic        colon;
    logic        am_led;

    modport master (
        output digi_clock, AM, blank_lz,
        input  seg, dig_en, colon, am_led
    );

    modport slave (
        input  digi_clock, AM, blank_lz,
        output seg, dig_en, colon, am_led
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexes a six-digit BCD time onto a shared active-low segment bus.
// A shadow copy of the time word is taken once per frame so a frame never
// mixes two times; every slot starts with a short all-dark guard window to
// avoid ghosting. A colon LED is lit for HALF_SEC_SLOTS slots after each
// seconds change, and an AM LED mirrors the captured AM flag.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   bus    seg7_scan_driver_if.slave (time word in, display signals out)
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int SCAN_DIV       = 1000,
    parameter int GUARD          = 8,
    parameter int HALF_SEC_SLOTS = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    seg7_scan_driver_if.slave     bus
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HS_W  = (HALF_SEC_SLOTS > 0) ? $clog2(HALF_SEC_SLOTS + 1) : 1;

    typedef enum logic {IDLE = 1'b0, ON = 1'b1} colon_state_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [23:0]      shadow_q, shadow_d;
    logic             am_q, am_d;
    logic             shadow_vld_q, shadow_vld_d;
    logic [6:0]       seg_q, seg_d;
    logic [5:0]       dig_en_q, dig_en_d;
    colon_state_e     state_q, state_d;
    logic [HS_W-1:0]  hs_q, hs_d;

    logic             snap;
    logic             slot_start;
    logic             wrap;
    logic             sec_changed;
    logic             blank_now;
    logic [3:0]       nib;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;   // illegal BCD shows a dash
        endcase
        return s;
    endfunction

    assign slot_start = (cnt_q == '0);
    assign snap       = slot_start && (idx_q == 3'd0);
    assign wrap       = (cnt_q == CNT_W'(SCAN_DIV - 1));

    // Shadow registers; downstream logic uses the _d view so the slot that
    // takes the snapshot already displays the freshly captured digit.
    always_comb begin
        shadow_d     = snap ? bus.digi_clock : shadow_q;
        am_d         = snap ? bus.AM : am_q;
        shadow_vld_d = shadow_vld_q | snap;
    end

    // Slot counter and digit index
    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Digit select and decode
    always_comb begin
        case (idx_q)
            3'd0:    nib = shadow_d[23:20];
            3'd1:    nib = shadow_d[19:16];
            3'd2:    nib = shadow_d[15:12];
            3'd3:    nib = shadow_d[11:8];
            3'd4:    nib = shadow_d[7:4];
            default: nib = shadow_d[3:0];
        endcase

        blank_now = (idx_q == 3'd0) && bus.blank_lz && (shadow_d[23:20] == 4'd0);

        // Segments only change at slot start, while every digit is dark.
        seg_d = slot_start ? bcd_to_seg(nib) : seg_q;

        dig_en_d = 6'h3F;
        if (!(cnt_q < CNT_W'(GUARD)) && !blank_now) begin
            dig_en_d = ~(6'b100000 >> idx_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shadow_q     <= 24'h0;
            am_q         <= 1'b0;
            shadow_vld_q <= 1'b0;
            seg_q        <= 7'h7F;
            dig_en_q     <= 6'h3F;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            am_q         <= am_d;
            shadow_vld_q <= shadow_vld_d;
            seg_q        <= seg_d;
            dig_en_q     <= dig_en_d;
        end
    end

    // Colon FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hs_q    <= '0;
        end else begin
            state_q <= state_d;
            hs_q    <= hs_d;
        end
    end

    // The previous snapshot's seconds units is still in shadow_q at the
    // snapshot edge; the valid flag stops the first snapshot from comparing
    // against the reset value.
    assign sec_changed = snap && shadow_vld_q && (bus.digi_clock[3:0] != shadow_q[3:0]);

    // Colon FSM: next state. The countdown ticks at each slot start so the
    // lit time lines up with whole displayed slots; a reload wins over a
    // countdown reaching zero on the same edge.
    always_comb begin
        state_d = state_q;
        hs_d    = hs_q;
        if (sec_changed) begin
            state_d = ON;
            hs_d    = HS_W'(HALF_SEC_SLOTS);
        end else if ((state_q == ON) && slot_start) begin
            if (hs_q <= HS_W'(1)) begin
                state_d = IDLE;
                hs_d    = '0;
            end else begin
                hs_d = hs_q - HS_W'(1);
            end
        end
    end

    // Colon FSM: outputs
    always_comb begin
        bus.colon = (state_q == ON);
    end

    assign bus.seg    = seg_q;
    assign bus.dig_en = dig_en_q;
    assign bus.am_led = am_q;

endmodule
